// File: rtl/core_sequencer.sv
// core_sequencer
// ----------------------------------------------------------------------------
// Multi-cycle sequencer for the RV32I core. Each instruction is stepped
// through FETCH -> DECODE -> EXEC -> [MEM] -> WB. The sequencer issues the
// datapath strobes and owns the single shared instruction/data memory port.
// A wait counter traps a stalled memory access into a sticky ERROR state.
//
// Handshake: while mem_req is high, mem_req/mem_we/addr_sel hold steady
// until the cycle in which mem_ready is sampled high. That cycle completes
// the access. mem_ready is ignored whenever mem_req is low.
//
// Ports
//   clk, rst          rising-edge clock, synchronous active-high reset
//   run               allows instruction issue (sampled in IDLE and WB)
//   mem_read..jalr    decode signals from the control unit
//   branch_taken      branch comparison result, valid in WB
//   mem_ready         memory completes the current access this cycle
//   mem_req, mem_we   memory request and write qualifier
//   addr_sel          0 = PC addresses memory, 1 = ALU result
//   ir_write          load IR (FETCH & mem_ready)
//   mdr_write         load MDR (MEM & mem_ready & load)
//   rf_we, pc_write   register file write, PC update (WB only)
//   pc_src            00 PC+4, 01 PC+imm, 10 (rs1+imm)&~1
//   state             current FSM state (debug)
//   busy              high outside IDLE and ERROR
//   bus_err           sticky bus-timeout flag
//   instret           retired-instruction count (wraps)
// ----------------------------------------------------------------------------
module core_sequencer #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             mem_read,
    input  logic             mem_write,
    input  logic             reg_write,
    input  logic             branch,
    input  logic             jal,
    input  logic             jalr,
    input  logic             branch_taken,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             addr_sel,
    output logic             ir_write,
    output logic             mdr_write,
    output logic             rf_we,
    output logic             pc_write,
    output logic [1:0]       pc_src,
    output logic [2:0]       state,
    output logic             busy,
    output logic             bus_err,
    output logic [CNT_W-1:0] instret
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_ERROR  = 3'd6,
        S_UNUSED = 3'd7
    } state_e;

    // Counter value on which a still-waiting access traps.
    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_e           state_q, state_d;
    logic [15:0]      wait_q, wait_d;
    logic [CNT_W-1:0] instret_q;
    logic             bus_err_q;

    // Next-state and wait-counter logic.
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        case (state_q)
            S_IDLE: begin
                if (run) begin
                    state_d = S_FETCH;
                    wait_d  = '0;
                end
            end
            S_FETCH, S_MEM: begin
                // A ready in the last allowed cycle still completes normally.
                if (mem_ready) begin
                    state_d = (state_q == S_FETCH) ? S_DECODE : S_WB;
                end else if (wait_q == WAIT_LAST) begin
                    state_d = S_ERROR;
                end else begin
                    wait_d = wait_q + 16'd1;
                end
            end
            S_DECODE: state_d = S_EXEC;
            S_EXEC: begin
                if (mem_read || mem_write) begin
                    state_d = S_MEM;
                    wait_d  = '0;
                end else begin
                    state_d = S_WB;
                end
            end
            S_WB: begin
                if (run) begin
                    state_d = S_FETCH;
                    wait_d  = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ERROR: state_d = S_ERROR;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            wait_q    <= '0;
            instret_q <= '0;
            bus_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            if (state_q == S_WB) begin
                instret_q <= instret_q + 1'b1;
            end
            if (state_d == S_ERROR) begin
                bus_err_q <= 1'b1;
            end
        end
    end

    // Strobes decode from the registered state; ir_write and mdr_write are
    // additionally qualified by the completing mem_ready.
    assign mem_req   = (state_q == S_FETCH) || (state_q == S_MEM);
    assign addr_sel  = (state_q == S_MEM);
    // Both mem_read and mem_write set is treated as a store.
    assign mem_we    = (state_q == S_MEM) && mem_write;
    assign ir_write  = (state_q == S_FETCH) && mem_ready;
    assign mdr_write = (state_q == S_MEM) && mem_ready && mem_read && !mem_write;
    assign rf_we     = (state_q == S_WB) && reg_write && !mem_write;
    assign pc_write  = (state_q == S_WB);

    always_comb begin
        pc_src = 2'b00;
        if (state_q == S_WB) begin
            if (jalr) begin
                pc_src = 2'b10;
            end else if (jal || (branch && branch_taken)) begin
                pc_src = 2'b01;
            end
        end
    end

    assign state   = state_q;
    assign busy    = (state_q != S_IDLE) && (state_q != S_ERROR);
    assign bus_err = bus_err_q;
    assign instret = instret_q;

endmodule

// File: tb/tb_core_sequencer.sv
// Directed bench for core_sequencer (TIMEOUT_CYCLES=4, CNT_W=3 so the
// retired-instruction counter wraps within a short run).
module tb_core_sequencer;

    localparam int CNT_W = 3;

    logic             clk = 1'b0;
    logic             rst, run, mem_read, mem_write, reg_write;
    logic             branch, jal, jalr, branch_taken, mem_ready;
    logic             mem_req, mem_we, addr_sel, ir_write, mdr_write;
    logic             rf_we, pc_write, busy, bus_err;
    logic [1:0]       pc_src;
    logic [2:0]       state;
    logic [CNT_W-1:0] instret;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    core_sequencer #(.TIMEOUT_CYCLES(4), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .run(run),
        .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
        .branch(branch), .jal(jal), .jalr(jalr), .branch_taken(branch_taken),
        .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel),
        .ir_write(ir_write), .mdr_write(mdr_write), .rf_we(rf_we),
        .pc_write(pc_write), .pc_src(pc_src), .state(state), .busy(busy),
        .bus_err(bus_err), .instret(instret)
    );

    // Advance one clock; inputs change and outputs are checked 2 ns later.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_decode(input logic rd, input logic wr, input logic rw,
                              input logic br, input logic j, input logic jr);
        mem_read  = rd;
        mem_write = wr;
        reg_write = rw;
        branch    = br;
        jal       = j;
        jalr      = jr;
    endtask

    initial begin
        rst = 1'b1; run = 1'b0; mem_ready = 1'b0; branch_taken = 1'b0;
        set_decode(0, 0, 0, 0, 0, 0);
        tick();
        tick();
        chk("reset_state", 32'(state), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_mem_req", 32'(mem_req), 32'd0);
        chk("reset_instret", 32'(instret), 32'd0);
        chk("reset_bus_err", 32'(bus_err), 32'd0);

        // ADD stream, zero-wait memory: F,D,E,WB every 4 cycles.
        rst = 1'b0; run = 1'b1; mem_ready = 1'b1;
        set_decode(0, 0, 1, 0, 0, 0);
        tick();
        chk("add_fetch_req", 32'(mem_req), 32'd1);
        chk("add_fetch_addr_sel", 32'(addr_sel), 32'd0);
        chk("add_fetch_ir_write", 32'(ir_write), 32'd1);
        chk("add_fetch_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 3; i++) begin
            chk("add_state_fetch", 32'(state), 32'd1);
            chk("add_instret", 32'(instret), 32'(i));
            chk("add_rf_we_fetch", 32'(rf_we), 32'd0);
            tick();
            chk("add_state_decode", 32'(state), 32'd2);
            chk("add_decode_req", 32'(mem_req), 32'd0);
            tick();
            chk("add_state_exec", 32'(state), 32'd3);
            chk("add_rf_we_exec", 32'(rf_we), 32'd0);
            tick();
            chk("add_state_wb", 32'(state), 32'd5);
            chk("add_rf_we_wb", 32'(rf_we), 32'd1);
            chk("add_pc_write", 32'(pc_write), 32'd1);
            chk("add_pc_src", 32'(pc_src), 32'd0);
            tick();
        end
        chk("add_instret_3", 32'(instret), 32'd3);

        // Load with two wait cycles in MEM.
        set_decode(1, 0, 1, 0, 0, 0);
        tick();
        tick();
        chk("ld_state_exec", 32'(state), 32'd3);
        mem_ready = 1'b0;
        tick();
        for (int i = 0; i < 2; i++) begin
            chk("ld_state_mem_wait", 32'(state), 32'd4);
            chk("ld_req_held", 32'(mem_req), 32'd1);
            chk("ld_addr_sel_held", 32'(addr_sel), 32'd1);
            chk("ld_mem_we", 32'(mem_we), 32'd0);
            chk("ld_mdr_wait", 32'(mdr_write), 32'd0);
            tick();
        end
        chk("ld_state_mem_last", 32'(state), 32'd4);
        mem_ready = 1'b1;
        #1;
        chk("ld_mdr_pulse", 32'(mdr_write), 32'd1);
        tick();
        chk("ld_state_wb", 32'(state), 32'd5);
        chk("ld_mdr_wb", 32'(mdr_write), 32'd0);
        chk("ld_rf_we", 32'(rf_we), 32'd1);
        tick();
        chk("ld_state_fetch", 32'(state), 32'd1);
        chk("ld_instret", 32'(instret), 32'd4);

        // Store.
        set_decode(0, 1, 0, 0, 0, 0);
        tick();
        tick();
        tick();
        chk("st_state_mem", 32'(state), 32'd4);
        chk("st_mem_we", 32'(mem_we), 32'd1);
        chk("st_mdr", 32'(mdr_write), 32'd0);
        tick();
        chk("st_state_wb", 32'(state), 32'd5);
        chk("st_rf_we", 32'(rf_we), 32'd0);
        chk("st_pc_src", 32'(pc_src), 32'd0);
        tick();
        chk("st_instret", 32'(instret), 32'd5);

        // Branch: taken vs not taken in the same WB cycle.
        set_decode(0, 0, 0, 1, 0, 0);
        tick();
        tick();
        tick();
        chk("br_state_wb", 32'(state), 32'd5);
        branch_taken = 1'b1;
        #1;
        chk("br_taken_src", 32'(pc_src), 32'd1);
        branch_taken = 1'b0;
        #1;
        chk("br_not_taken_src", 32'(pc_src), 32'd0);
        tick();
        chk("br_instret", 32'(instret), 32'd6);

        // jal and jalr both set: jalr wins.
        set_decode(0, 0, 1, 0, 1, 1);
        tick();
        tick();
        tick();
        chk("jalr_src", 32'(pc_src), 32'd2);
        tick();
        chk("jalr_instret", 32'(instret), 32'd7);

        // ADD with run dropped in EXEC; instret wraps 7 -> 0.
        set_decode(0, 0, 1, 0, 0, 0);
        tick();
        tick();
        chk("drop_state_exec", 32'(state), 32'd3);
        run = 1'b0;
        tick();
        chk("drop_state_wb", 32'(state), 32'd5);
        tick();
        chk("drop_state_idle", 32'(state), 32'd0);
        chk("drop_busy", 32'(busy), 32'd0);
        chk("wrap_instret", 32'(instret), 32'd0);
        mem_ready = 1'b1;
        #1;
        chk("idle_ignores_ready", 32'(ir_write), 32'd0);
        mem_ready = 1'b0;
        run = 1'b1;
        tick();
        chk("restart_fetch", 32'(state), 32'd1);

        // Ready arrives on the 4th wait cycle: no trap.
        chk("late_ir_wait", 32'(ir_write), 32'd0);
        tick();
        tick();
        tick();
        chk("late_state_fetch", 32'(state), 32'd1);
        mem_ready = 1'b1;
        #1;
        chk("late_ir_write", 32'(ir_write), 32'd1);
        tick();
        chk("late_state_decode", 32'(state), 32'd2);
        chk("late_bus_err", 32'(bus_err), 32'd0);
        tick();
        tick();
        chk("late_state_wb", 32'(state), 32'd5);
        mem_ready = 1'b0;

        // Ready never arrives: ERROR after 4 wait cycles.
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("to_state_fetch", 32'(state), 32'd1);
            tick();
        end
        chk("to_state_error", 32'(state), 32'd6);
        chk("to_bus_err", 32'(bus_err), 32'd1);
        chk("to_busy", 32'(busy), 32'd0);
        chk("to_mem_req", 32'(mem_req), 32'd0);
        mem_ready = 1'b1;
        tick();
        tick();
        chk("to_sticky_state", 32'(state), 32'd6);
        chk("to_sticky_err", 32'(bus_err), 32'd1);

        rst = 1'b1;
        tick();
        chk("rst_err_state", 32'(state), 32'd0);
        chk("rst_err_bus_err", 32'(bus_err), 32'd0);
        chk("rst_err_instret", 32'(instret), 32'd0);

        // Reset in the middle of a pending fetch drops the request.
        rst = 1'b0; mem_ready = 1'b0;
        tick();
        chk("mid_fetch_req", 32'(mem_req), 32'd1);
        rst = 1'b1;
        tick();
        chk("mid_rst_req", 32'(mem_req), 32'd0);
        chk("mid_rst_state", 32'(state), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/core_sequencer.md
Name: core_sequencer

Overview:
Multi-cycle sequencer FSM for the RV32I core. It steps each instruction through fetch, decode, execute, memory and writeback, and issues the datapath strobes. It also owns the single shared instruction/data memory port through a req/ready handshake with a bus-timeout trap. Decode signals come from the combinational control unit driven by the instruction register.

Parameters:
TIMEOUT_CYCLES, 255, maximum wait cycles with mem_req high and mem_ready low before trapping (legal range 1..65535).
CNT_W, 32, width of the retired-instruction counter.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
run  input  1  enables instruction issue; sampled in IDLE and WB
mem_read  input  1  from control unit: load
mem_write  input  1  from control unit: store
reg_write  input  1  from control unit: writes rd
branch  input  1  from control unit: conditional branch
jal  input  1  from control unit
jalr  input  1  from control unit
branch_taken  input  1  comparison result from datapath, valid in WB
mem_ready  input  1  memory completes current access this cycle
mem_req  output  1  memory access request
mem_we  output  1  write enable qualifying mem_req
addr_sel  output  1  0 = PC drives memory address, 1 = ALU result
ir_write  output  1  load instruction register
mdr_write  output  1  load memory data register
rf_we  output  1  register file write enable
pc_write  output  1  update PC
pc_src  output  2  00 = PC+4, 01 = PC+imm, 10 = (rs1+imm)&~1
state  output  3  current FSM state (debug)
busy  output  1  high in every state except IDLE and ERROR
bus_err  output  1  sticky timeout flag
instret  output  CNT_W  retired-instruction count

Behaviour:
- Reset (sync, priority over everything): state=IDLE, wait counter=0, instret=0, bus_err=0.
- Strobes decode from state (Moore). The exceptions are ir_write and mdr_write, which are also gated by mem_ready (Mealy).
- In IDLE and ERROR all strobes are 0.
- State encodings: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, ERROR=6; 7 is unused and recovers to IDLE.
- IDLE: busy=0. If run=1, go to FETCH next cycle.
- FETCH:
  - Drives mem_req=1, addr_sel=0, mem_we=0.
  - ir_write = mem_ready. On mem_ready, go to DECODE.
- DECODE: one cycle with no strobes; go to EXEC. Decode inputs are stable from here until the next FETCH.
- EXEC: one cycle. If mem_read|mem_write, go to MEM; else go to WB.
- MEM:
  - Drives mem_req=1, addr_sel=1, mem_we=mem_write.
  - mdr_write = mem_ready & mem_read & ~mem_write.
  - On mem_ready, go to WB.
  - If mem_read and mem_write are both set, treat the access as a store.
- WB:
  - rf_we = reg_write & ~mem_write.
  - pc_write=1; instret increments, wrapping 2^CNT_W-1 -> 0.
  - pc_src priority: jalr -> 10; else jal -> 01; else branch & branch_taken -> 01; else 00.
  - Next state: FETCH if run=1, else IDLE.
- Latency with zero-wait memory: ALU/branch/jump instructions take 4 cycles, loads/stores take 5. Each mem_ready-low cycle in FETCH or MEM adds 1.
- Handshake:
  - mem_req, mem_we and addr_sel stay constant from assertion until the cycle mem_ready is sampled high.
  - mem_ready while mem_req=0 is ignored.
- Timeout:
  - The wait counter clears on entry to FETCH and MEM.
  - It increments each cycle mem_req=1 and mem_ready=0.
  - If mem_ready=0 while the counter equals TIMEOUT_CYCLES-1, go to ERROR next cycle.
  - mem_ready=1 in that same cycle wins: normal transition, no error.
- ERROR: bus_err=1, busy=0, no strobes. Only rst exits.
- run deasserted mid-instruction: the instruction completes through WB and retires, then the FSM enters IDLE.
- rst mid-access: the outstanding request is abandoned and mem_req=0 from the next cycle.

Test Plan:
- ADD sequence, mem_ready tied 1, run=1: FETCH,DECODE,EXEC,WB repeat every 4 cycles; rf_we=1 only in WB; after 3 instructions instret=3.
- Load with mem_ready low 2 cycles in MEM: MEM lasts 3 cycles; mdr_write pulses once on the ready cycle; mem_req and addr_sel=1 held throughout; total 7 cycles.
- Store (mem_write=1, reg_write=0): mem_we=1 in MEM; rf_we=0 in WB; pc_src=00.
- Branch with branch_taken=1 -> pc_src=01; branch_taken=0 -> 00. jal=1,jalr=1 -> 10.
- TIMEOUT_CYCLES=4, mem_ready held 0 in FETCH: ERROR entered after 4 wait cycles, bus_err=1 and sticky. Variant with ready on the 4th cycle: DECODE, no error. rst clears to IDLE with bus_err=0.
- run dropped in EXEC: WB still retires (instret+1), then IDLE; run=1 restarts at FETCH the next cycle.
